// File: rtl/freq_meter_if.sv
// Port bundle for freq_meter: measured input, run control, and the registered results.
// count_valid / period_valid are single-cycle strobes with no back-pressure: the consumer must
// capture edge_count / period on the cycle its strobe is high, and the data holds until the next strobe.
interface freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             overflow;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             busy;
  logic             state;

  modport master (
    output sig_in, enable,
    input  edge_count, count_valid, overflow, period, period_valid, busy, state
  );

  modport slave (
    input  sig_in, enable,
    output edge_count, count_valid, overflow, period, period_valid, busy, state
  );
endinterface

// File: rtl/freq_meter.sv
// Gated rising-edge counter plus edge-to-edge period meter for a divided clock sampled
// as data in the clk_in domain. state is exported on the bus for observation.
module freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk_in,
  input logic         reset_n,
  freq_meter_if.slave bus
);
  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [0:0]       IDLE      = 1'b0;
  localparam logic [0:0]       GATE      = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic [CNT_W-1:0]       rise_w;

  logic [0:0]             state_q;
  logic [GW-1:0]          gate_cnt_q;
  logic [CNT_W-1:0]       edge_acc_q;
  logic                   sat_q;
  logic [CNT_W-1:0]       edge_count_q;
  logic                   overflow_q;
  logic                   count_valid_q;

  logic [CNT_W-1:0]       per_cnt_q;
  logic                   first_q;
  logic [CNT_W-1:0]       period_q;
  logic                   period_valid_q;

  logic                   acc_full;
  logic                   per_full;
  logic                   window_end;

  assign rise       = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign rise_w     = {{(CNT_W-1){1'b0}}, rise};
  assign acc_full   = (edge_acc_q == CNT_MAX);
  assign per_full   = (per_cnt_q == CNT_MAX);
  assign window_end = (state_q == GATE) && (gate_cnt_q == GATE_LAST);

  // Synchronizer and edge detector run in every state.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gate_cnt_q    <= '0;
      edge_acc_q    <= '0;
      sat_q         <= 1'b0;
      edge_count_q  <= '0;
      overflow_q    <= 1'b0;
      count_valid_q <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      case (state_q)
        GATE: begin
          if (window_end) begin
            // The last-cycle rise belongs to this window, so fold it in here.
            edge_count_q  <= acc_full ? CNT_MAX : edge_acc_q + rise_w;
            overflow_q    <= sat_q | (rise & acc_full);
            count_valid_q <= 1'b1;
            gate_cnt_q    <= '0;
            edge_acc_q    <= '0;
            sat_q         <= 1'b0;
            if (!bus.enable) state_q <= IDLE;
          end else if (!bus.enable) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_acc_q <= '0;
            sat_q      <= 1'b0;
          end else begin
            gate_cnt_q <= gate_cnt_q + GW'(1);
            if (rise) begin
              if (acc_full) sat_q <= 1'b1;
              else          edge_acc_q <= edge_acc_q + rise_w;
            end
          end
        end
        default: begin
          gate_cnt_q <= '0;
          edge_acc_q <= '0;
          sat_q      <= 1'b0;
          if (bus.enable) state_q <= GATE;
        end
      endcase
    end
  end

  // Period path ignores the gate; it only needs enable to stay high between two rises.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      per_cnt_q      <= '0;
      first_q        <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (!bus.enable) begin
        per_cnt_q <= '0;
        first_q   <= 1'b0;
      end else if (rise) begin
        if (first_q) begin
          period_q       <= per_full ? CNT_MAX : per_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          period_valid_q <= 1'b1;
        end
        per_cnt_q <= '0;
        first_q   <= 1'b1;
      end else if (!per_full) begin
        per_cnt_q <= per_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.edge_count   = edge_count_q;
  assign bus.count_valid  = count_valid_q;
  assign bus.overflow     = overflow_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.busy         = (state_q == GATE);
  assign bus.state        = state_q[0];
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 16-bit and a 4-bit instance see the same stimulus; results are
// checked against edge counts computed from the recorded sig_in history.
module tb_freq_meter;
  localparam int G    = 100;
  localparam int S    = 2;
  localparam int MAXC = 20000;

  logic clk_in = 1'b0;
  logic reset_n;
  always #5 clk_in = ~clk_in;

  freq_meter_if #(.CNT_W(16)) m_if ();
  freq_meter_if #(.CNT_W(4))  s_if ();
  assign s_if.sig_in = m_if.sig_in;
  assign s_if.enable = m_if.enable;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(S)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .bus(m_if));
  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) sat_dut (
    .clk_in(clk_in), .reset_n(reset_n), .bus(s_if));

  int   cyc;
  int   errors;
  int   checks;
  logic sig_at [0:MAXC-1];
  int   cv_cyc[$], cv_val[$], cv_ovf[$], sv_val[$], sv_ovf[$], pv_cyc[$], pv_val[$];
  logic [15:0] exp_q[$];
  int   exp_cyc_q[$];

  // Edge index and the sig_in value each edge samples.
  initial begin
    cyc = 0;
    for (int i = 0; i < MAXC; i++) sig_at[i] = 1'b0;
    forever begin
      @(posedge clk_in);
      cyc++;
      if (cyc < MAXC) sig_at[cyc] = m_if.sig_in;
    end
  end

  // Output monitor on the falling edge; strobes must never last two cycles.
  initial begin
    logic cv_prev, pv_prev;
    cv_prev = 1'b0;
    pv_prev = 1'b0;
    forever begin
      @(negedge clk_in);
      if (m_if.count_valid === 1'b1) begin
        cv_cyc.push_back(cyc);
        cv_val.push_back(int'(m_if.edge_count));
        cv_ovf.push_back(int'(m_if.overflow));
        checks++;
        if (cv_prev !== 1'b0) begin
          errors++; $display("FAIL count_valid_width: got 2+ cycles expected 1 at edge %0d", cyc);
        end
      end
      if (s_if.count_valid === 1'b1) begin
        sv_val.push_back(int'(s_if.edge_count));
        sv_ovf.push_back(int'(s_if.overflow));
      end
      if (m_if.period_valid === 1'b1) begin
        pv_cyc.push_back(cyc);
        pv_val.push_back(int'(m_if.period));
        checks++;
        if (pv_prev !== 1'b0) begin
          errors++; $display("FAIL period_valid_width: got 2+ cycles expected 1 at edge %0d", cyc);
        end
      end
      cv_prev = m_if.count_valid;
      pv_prev = m_if.period_valid;
    end
  end

  // Reference: a rise acted on at edge n is a 0->1 step of sig_in seen S and S+1 edges earlier.
  function automatic int rise_at(int n);
    if (n - S - 1 < 0 || n >= MAXC) return 0;
    return (sig_at[n-S] === 1'b1 && sig_at[n-S-1] === 1'b0) ? 1 : 0;
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic start_clean();
    m_if.enable = 1'b0;
    m_if.sig_in = 1'b0;
    repeat (S + 6) tick();
    cv_cyc.delete(); cv_val.delete(); cv_ovf.delete();
    sv_val.delete(); sv_ovf.delete(); pv_cyc.delete(); pv_val.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m_if.sig_in = 1'b0;
    m_if.enable = 1'b0;
    repeat (4) tick();
    checks += 8;
    if (m_if.edge_count !== 16'd0) begin errors++; $display("FAIL reset_edge_count: got %0d expected 0", m_if.edge_count); end
    if (m_if.count_valid !== 1'b0) begin errors++; $display("FAIL reset_count_valid: got %b expected 0", m_if.count_valid); end
    if (m_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", m_if.overflow); end
    if (m_if.period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", m_if.period); end
    if (m_if.period_valid !== 1'b0) begin errors++; $display("FAIL reset_period_valid: got %b expected 0", m_if.period_valid); end
    if (m_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m_if.busy); end
    if (m_if.state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", m_if.state); end
    if (s_if.edge_count !== 4'd0) begin errors++; $display("FAIL reset_sat_edge_count: got %0d expected 0", s_if.edge_count); end
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_constant();
    int e0;
    start_clean();
    m_if.enable = 1'b1;
    e0 = cyc + 1;
    repeat (3 * G + 3) tick();
    m_if.enable = 1'b0;
    repeat (2) tick();
    checks += 3;
    if (cv_cyc.size() !== 3) begin errors++; $display("FAIL const_windows: got %0d expected 3", cv_cyc.size()); end
    if (pv_cyc.size() !== 0) begin errors++; $display("FAIL const_period_valid: got %0d pulses expected 0", pv_cyc.size()); end
    if (m_if.period !== 16'd0) begin errors++; $display("FAIL const_period: got %0d expected 0", m_if.period); end
    for (int k = 0; k < cv_cyc.size() && k < 3; k++) begin
      checks += 3;
      if (cv_cyc[k] !== e0 + (k + 1) * G) begin errors++; $display("FAIL const_cv_time[%0d]: got %0d expected %0d", k, cv_cyc[k], e0 + (k + 1) * G); end
      if (cv_val[k] !== 0) begin errors++; $display("FAIL const_count[%0d]: got %0d expected 0", k, cv_val[k]); end
      if (sv_val[k] !== 0) begin errors++; $display("FAIL const_sat_count[%0d]: got %0d expected 0", k, sv_val[k]); end
    end
  endtask

  task automatic test_periodic();
    int e0;
    start_clean();
    m_if.enable = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 5 * G + 4; i++) begin
      m_if.sig_in = (i < 3 * G) ? i[1] : 1'b0;
      tick();
    end
    m_if.enable = 1'b0;
    repeat (2) tick();
    checks++;
    if (cv_cyc.size() !== 5) begin errors++; $display("FAIL periodic_windows: got %0d expected 5", cv_cyc.size()); end
    for (int k = 0; k < cv_cyc.size() && k < 5; k++) begin
      checks += 5;
      if (cv_cyc[k] !== e0 + (k + 1) * G) begin errors++; $display("FAIL periodic_cv_time[%0d]: got %0d expected %0d", k, cv_cyc[k], e0 + (k + 1) * G); end
      if (cv_val[k] !== ((k < 3) ? 25 : 0)) begin errors++; $display("FAIL periodic_count[%0d]: got %0d expected %0d", k, cv_val[k], (k < 3) ? 25 : 0); end
      if (cv_ovf[k] !== 0) begin errors++; $display("FAIL periodic_overflow[%0d]: got %0d expected 0", k, cv_ovf[k]); end
      if (sv_val[k] !== ((k < 3) ? 15 : 0)) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", k, sv_val[k], (k < 3) ? 15 : 0); end
      if (sv_ovf[k] !== ((k < 3) ? 1 : 0)) begin errors++; $display("FAIL sat_overflow[%0d]: got %0d expected %0d", k, sv_ovf[k], (k < 3) ? 1 : 0); end
    end
    // 75 rises at edges e0+4, e0+8, ... e0+300 give 74 period reports.
    checks++;
    if (pv_cyc.size() !== 74) begin errors++; $display("FAIL periodic_period_pulses: got %0d expected 74", pv_cyc.size()); end
    for (int k = 0; k < pv_cyc.size() && k < 74; k++) begin
      checks += 2;
      if (pv_cyc[k] !== e0 + 8 + 4 * k) begin errors++; $display("FAIL period_time[%0d]: got %0d expected %0d", k, pv_cyc[k], e0 + 8 + 4 * k); end
      if (pv_val[k] !== 4) begin errors++; $display("FAIL period_value[%0d]: got %0d expected 4", k, pv_val[k]); end
    end
  endtask

  task automatic test_abort();
    int e0;
    start_clean();
    m_if.enable = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i <= 3 * G + 51; i++) begin
      m_if.sig_in = (i < G + 51) ? i[1] : 1'b0;
      m_if.enable = (i <= G + 50);
      tick();
      if (i == G + 50) begin
        checks++;
        if (m_if.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", m_if.busy); end
      end
      if (i == G + 51) begin
        checks++;
        if (m_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", m_if.busy); end
      end
    end
    checks += 3;
    if (cv_cyc.size() !== 1) begin errors++; $display("FAIL abort_windows: got %0d expected 1", cv_cyc.size()); end
    else if (cv_cyc[0] !== e0 + G) begin errors++; $display("FAIL abort_cv_time: got %0d expected %0d", cv_cyc[0], e0 + G); end
    if (m_if.edge_count !== 16'd25) begin errors++; $display("FAIL abort_hold_count: got %0d expected 25", m_if.edge_count); end
    if (m_if.overflow !== 1'b0) begin errors++; $display("FAIL abort_hold_overflow: got %b expected 0", m_if.overflow); end
  endtask

  task automatic test_boundary_drop();
    int e0;
    start_clean();
    m_if.enable = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < 2 * G + 10; i++) begin
      m_if.sig_in = (i < G) ? i[1] : 1'b0;
      m_if.enable = (i < G);
      tick();
      if (i == G - 1) begin
        checks++;
        if (m_if.busy !== 1'b1) begin errors++; $display("FAIL drop_last_busy_before: got %b expected 1", m_if.busy); end
      end
      if (i == G) begin
        checks += 2;
        if (m_if.count_valid !== 1'b1) begin errors++; $display("FAIL drop_last_cv: got %b expected 1", m_if.count_valid); end
        if (m_if.busy !== 1'b0) begin errors++; $display("FAIL drop_last_busy_after: got %b expected 0", m_if.busy); end
      end
    end
    checks++;
    if (cv_cyc.size() !== 1) begin errors++; $display("FAIL drop_last_windows: got %0d expected 1", cv_cyc.size()); end
    else begin
      checks++;
      if (cv_val[0] !== 25) begin errors++; $display("FAIL drop_last_count: got %0d expected 25", cv_val[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    start_clean();
    m_if.enable = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < G + 56; i++) begin
      m_if.sig_in = (i < 30) ? i[1] : 1'b0;
      reset_n = (i != 41);
      tick();
      if (i == 41) begin
        checks += 8;
        if (m_if.edge_count !== 16'd0) begin errors++; $display("FAIL rstmid_edge_count: got %0d expected 0", m_if.edge_count); end
        if (m_if.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow: got %b expected 0", m_if.overflow); end
        if (m_if.period !== 16'd0) begin errors++; $display("FAIL rstmid_period: got %0d expected 0", m_if.period); end
        if (m_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", m_if.busy); end
        if (m_if.state !== 1'b0) begin errors++; $display("FAIL rstmid_state: got %b expected 0", m_if.state); end
        if (m_if.count_valid !== 1'b0) begin errors++; $display("FAIL rstmid_count_valid: got %b expected 0", m_if.count_valid); end
        if (s_if.edge_count !== 4'd0) begin errors++; $display("FAIL rstmid_sat_count: got %0d expected 0", s_if.edge_count); end
        if (s_if.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_sat_overflow: got %b expected 0", s_if.overflow); end
      end
    end
    reset_n = 1'b1;
    checks++;
    if (cv_cyc.size() !== 1) begin errors++; $display("FAIL rstmid_windows: got %0d expected 1", cv_cyc.size()); end
    else begin
      checks++;
      if (cv_cyc[0] !== e0 + 41 + G + 1) begin errors++; $display("FAIL rstmid_cv_time: got %0d expected %0d", cv_cyc[0], e0 + 42 + G); end
    end
  endtask

  task automatic test_edge_boundary();
    for (int off = 0; off < 2; off++) begin
      int e0;
      start_clean();
      m_if.enable = 1'b1;
      e0 = cyc + 1;
      for (int i = 0; i < 2 * G + 8; i++) begin
        m_if.sig_in = (i >= G - S + off) && (i < 2 * G + 2);
        m_if.enable = (i <= 2 * G);
        tick();
      end
      checks++;
      if (cv_cyc.size() !== 2) begin errors++; $display("FAIL boundary_windows[%0d]: got %0d expected 2", off, cv_cyc.size()); end
      else begin
        checks += 2;
        if (cv_val[0] !== 1 - off) begin errors++; $display("FAIL boundary_first[%0d]: got %0d expected %0d", off, cv_val[0], 1 - off); end
        if (cv_val[1] !== off) begin errors++; $display("FAIL boundary_second[%0d]: got %0d expected %0d", off, cv_val[1], off); end
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int   e0, run, cnt, last_rise;
      logic cur;
      int   ecyc;
      logic [15:0] ev;
      start_clean();
      exp_q.delete();
      exp_cyc_q.delete();
      m_if.enable = 1'b1;
      e0 = cyc + 1;
      run = 0;
      cur = 1'b0;
      for (int i = 0; i < 2 * G + 12; i++) begin
        if (run == 0) begin
          cur = ~cur;
          run = $urandom_range(1, 10);
        end
        run--;
        m_if.sig_in = (i <= 2 * G) ? cur : 1'b0;
        m_if.enable = (i <= 2 * G);
        tick();
      end
      checks++;
      if (cv_cyc.size() !== 2) begin errors++; $display("FAIL rand_windows[%0d]: got %0d expected 2", t, cv_cyc.size()); end
      else begin
        for (int k = 0; k < 2; k++) begin
          cnt = 0;
          for (int n = e0 + 1 + k * G; n <= e0 + (k + 1) * G; n++) cnt += rise_at(n);
          exp_q.push_back(16'(cnt));
          ev = exp_q.pop_front();
          checks += 4;
          if (cv_cyc[k] !== e0 + (k + 1) * G) begin errors++; $display("FAIL rand_cv_time[%0d.%0d]: got %0d expected %0d", t, k, cv_cyc[k], e0 + (k + 1) * G); end
          if (cv_val[k] !== int'(ev)) begin errors++; $display("FAIL rand_count[%0d.%0d]: got %0d expected %0d", t, k, cv_val[k], ev); end
          if (sv_val[k] !== ((cnt > 15) ? 15 : cnt)) begin errors++; $display("FAIL rand_sat_count[%0d.%0d]: got %0d expected %0d", t, k, sv_val[k], (cnt > 15) ? 15 : cnt); end
          if (sv_ovf[k] !== ((cnt > 15) ? 1 : 0)) begin errors++; $display("FAIL rand_sat_overflow[%0d.%0d]: got %0d expected %0d", t, k, sv_ovf[k], (cnt > 15) ? 1 : 0); end
        end
      end
      // Period reports: one per rise after the first while enable stayed high.
      exp_q.delete();
      last_rise = -1;
      for (int n = e0; n <= e0 + 2 * G; n++) begin
        if (rise_at(n) == 1) begin
          if (last_rise >= 0) begin
            exp_q.push_back(16'(n - last_rise));
            exp_cyc_q.push_back(n);
          end
          last_rise = n;
        end
      end
      checks++;
      if (pv_cyc.size() !== exp_q.size()) begin
        errors++; $display("FAIL rand_period_pulses[%0d]: got %0d expected %0d", t, pv_cyc.size(), exp_q.size());
      end else begin
        for (int k = 0; k < pv_cyc.size(); k++) begin
          ev = exp_q.pop_front();
          ecyc = exp_cyc_q.pop_front();
          checks += 2;
          if (pv_val[k] !== int'(ev)) begin errors++; $display("FAIL rand_period[%0d.%0d]: got %0d expected %0d", t, k, pv_val[k], ev); end
          if (pv_cyc[k] !== ecyc) begin errors++; $display("FAIL rand_period_time[%0d.%0d]: got %0d expected %0d", t, k, pv_cyc[k], ecyc); end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    m_if.sig_in = 1'b0;
    m_if.enable = 1'b0;
    test_reset();
    test_constant();
    test_periodic();
    test_abort();
    test_boundary_drop();
    test_reset_mid();
    test_edge_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
